// File: rtl/siw_memory_pkg.sv
// Shared defaults and the read-tag type for the siw_memory arbiter slice.
package siw_memory_pkg;

    localparam int unsigned SIW_MEM_ADDR_W = 10;
    localparam int unsigned SIW_MEM_DATA_W = 32;
    localparam int unsigned SIW_MEM_RD_LAT = 2;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/siw_memory_arbiter_0_tag_pipe.sv
// Fixed-depth shift pipeline carrying read tags alongside the memory read latency.
module siw_memory_arbiter_0_tag_pipe
    import siw_memory_pkg::*;
#(
    parameter int unsigned DEPTH = 1 + SIW_MEM_RD_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/siw_memory_arbiter_0.sv
// Two-requester round-robin arbiter in front of a single BRAM port, with
// tagged in-order read return.
module siw_memory_arbiter_0
    import siw_memory_pkg::*;
#(
    parameter int unsigned ADDR_W = SIW_MEM_ADDR_W,
    parameter int unsigned DATA_W = SIW_MEM_DATA_W,
    parameter int unsigned RD_LAT = SIW_MEM_RD_LAT
) (
    input  logic              siw_memory_arbiter_0_clk,
    input  logic              siw_memory_arbiter_0_reset,
    input  logic              siw_memory_arbiter_0_init,
    input  logic              siw_memory_arbiter_0_req_0,
    input  logic              siw_memory_arbiter_0_we_0,
    input  logic [ADDR_W-1:0] siw_memory_arbiter_0_addr_0,
    input  logic [DATA_W-1:0] siw_memory_arbiter_0_wdata_0,
    input  logic              siw_memory_arbiter_0_req_1,
    input  logic              siw_memory_arbiter_0_we_1,
    input  logic [ADDR_W-1:0] siw_memory_arbiter_0_addr_1,
    input  logic [DATA_W-1:0] siw_memory_arbiter_0_wdata_1,
    output logic              siw_memory_arbiter_0_gnt_0,
    output logic              siw_memory_arbiter_0_gnt_1,
    output logic              siw_memory_arbiter_0_rvalid_0,
    output logic              siw_memory_arbiter_0_rvalid_1,
    output logic [DATA_W-1:0] siw_memory_arbiter_0_rdata,
    output logic              siw_memory_arbiter_0_mem_enable,
    output logic              siw_memory_arbiter_0_mem_write_en,
    output logic [ADDR_W-1:0] siw_memory_arbiter_0_mem_address,
    output logic [DATA_W-1:0] siw_memory_arbiter_0_mem_input_data,
    output logic [1:0]        siw_memory_arbiter_0_mem_conf,
    input  logic [DATA_W-1:0] siw_memory_arbiter_0_mem_output_data
);

    logic              ptr;
    logic              gnt_any;
    logic              gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    tag_t              tag_in;
    tag_t              tag_out;

    // Grant is combinational; ptr names the winner when both request.
    always_comb begin
        siw_memory_arbiter_0_gnt_0 = 1'b0;
        siw_memory_arbiter_0_gnt_1 = 1'b0;
        if (!siw_memory_arbiter_0_reset && !siw_memory_arbiter_0_init) begin
            if (siw_memory_arbiter_0_req_0 && (!siw_memory_arbiter_0_req_1 || !ptr)) begin
                siw_memory_arbiter_0_gnt_0 = 1'b1;
            end else if (siw_memory_arbiter_0_req_1) begin
                siw_memory_arbiter_0_gnt_1 = 1'b1;
            end
        end
    end

    assign gnt_any   = siw_memory_arbiter_0_gnt_0 | siw_memory_arbiter_0_gnt_1;
    assign gnt_id    = siw_memory_arbiter_0_gnt_1;
    assign sel_we    = gnt_id ? siw_memory_arbiter_0_we_1    : siw_memory_arbiter_0_we_0;
    assign sel_addr  = gnt_id ? siw_memory_arbiter_0_addr_1  : siw_memory_arbiter_0_addr_0;
    assign sel_wdata = gnt_id ? siw_memory_arbiter_0_wdata_1 : siw_memory_arbiter_0_wdata_0;

    // Address and write data hold their last value when idle; only enables drop.
    always_ff @(posedge siw_memory_arbiter_0_clk or posedge siw_memory_arbiter_0_reset) begin
        if (siw_memory_arbiter_0_reset) begin
            ptr                                 <= 1'b0;
            siw_memory_arbiter_0_mem_enable     <= 1'b0;
            siw_memory_arbiter_0_mem_write_en   <= 1'b0;
            siw_memory_arbiter_0_mem_address    <= '0;
            siw_memory_arbiter_0_mem_input_data <= '0;
        end else if (siw_memory_arbiter_0_init) begin
            ptr                               <= 1'b0;
            siw_memory_arbiter_0_mem_enable   <= 1'b0;
            siw_memory_arbiter_0_mem_write_en <= 1'b0;
        end else begin
            siw_memory_arbiter_0_mem_enable   <= gnt_any;
            siw_memory_arbiter_0_mem_write_en <= gnt_any & sel_we;
            if (gnt_any) begin
                ptr                                 <= ~gnt_id;
                siw_memory_arbiter_0_mem_address    <= sel_addr;
                siw_memory_arbiter_0_mem_input_data <= sel_wdata;
            end
        end
    end

    assign tag_in.valid = gnt_any & ~sel_we;
    assign tag_in.id    = gnt_id;

    siw_memory_arbiter_0_tag_pipe #(
        .DEPTH (1 + RD_LAT)
    ) u_tag_pipe (
        .clk     (siw_memory_arbiter_0_clk),
        .reset   (siw_memory_arbiter_0_reset),
        .clear   (siw_memory_arbiter_0_init),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign siw_memory_arbiter_0_rvalid_0  = tag_out.valid & ~tag_out.id;
    assign siw_memory_arbiter_0_rvalid_1  = tag_out.valid &  tag_out.id;
    assign siw_memory_arbiter_0_rdata     = siw_memory_arbiter_0_mem_output_data;
    assign siw_memory_arbiter_0_mem_conf  = 2'd0;

endmodule

// File: tb/tb_siw_memory_arbiter_0.sv
// Directed bench for siw_memory_arbiter_0 with a 2-cycle-latency BRAM model.
module tb_siw_memory_arbiter_0;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              init;
    logic              req_0, req_1, we_0, we_1;
    logic [ADDR_W-1:0] addr_0, addr_1;
    logic [DATA_W-1:0] wdata_0, wdata_1;
    logic              gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [DATA_W-1:0] rdata;
    logic              mem_enable, mem_write_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_input_data, mem_output_data;
    logic [1:0]        mem_conf;

    int n_chk  = 0;
    int n_pass = 0;

    siw_memory_arbiter_0 dut (
        .siw_memory_arbiter_0_clk             (clk),
        .siw_memory_arbiter_0_reset           (rst),
        .siw_memory_arbiter_0_init            (init),
        .siw_memory_arbiter_0_req_0           (req_0),
        .siw_memory_arbiter_0_we_0            (we_0),
        .siw_memory_arbiter_0_addr_0          (addr_0),
        .siw_memory_arbiter_0_wdata_0         (wdata_0),
        .siw_memory_arbiter_0_req_1           (req_1),
        .siw_memory_arbiter_0_we_1            (we_1),
        .siw_memory_arbiter_0_addr_1          (addr_1),
        .siw_memory_arbiter_0_wdata_1         (wdata_1),
        .siw_memory_arbiter_0_gnt_0           (gnt_0),
        .siw_memory_arbiter_0_gnt_1           (gnt_1),
        .siw_memory_arbiter_0_rvalid_0        (rvalid_0),
        .siw_memory_arbiter_0_rvalid_1        (rvalid_1),
        .siw_memory_arbiter_0_rdata           (rdata),
        .siw_memory_arbiter_0_mem_enable      (mem_enable),
        .siw_memory_arbiter_0_mem_write_en    (mem_write_en),
        .siw_memory_arbiter_0_mem_address     (mem_address),
        .siw_memory_arbiter_0_mem_input_data  (mem_input_data),
        .siw_memory_arbiter_0_mem_conf        (mem_conf),
        .siw_memory_arbiter_0_mem_output_data (mem_output_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: preloaded with 0xA5000000|addr, read data two cycles after enable.
    logic [DATA_W-1:0] mem [1024];
    logic [DATA_W-1:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            rd_p1 <= '0;
            rd_p2 <= '0;
        end else begin
            if (mem_enable) begin
                if (mem_write_en) mem[mem_address] <= mem_input_data;
                else              rd_p1 <= mem[mem_address];
            end
            rd_p2 <= rd_p1;
        end
    end
    assign mem_output_data = rd_p2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else             n_pass++;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        #2 rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        init = 1'b0;
        idle_inputs();
        tick();
        // Reset state, with a request held to show grants are masked.
        req_0 = 1'b1;
        #2;
        check("rst_gnt0",   32'(gnt_0), 0);
        check("rst_men",    32'(mem_enable), 0);
        check("rst_rv",     32'({rvalid_0, rvalid_1}), 0);
        check("rst_conf",   32'(mem_conf), 0);
        check("rst_addr",   32'(mem_address), 0);
        do_reset();

        // Single read: gnt at T, mem drive at T+1, rvalid at T+3.
        tick();
        req_0 = 1'b1; addr_0 = 10'h010;
        #2 check("t1_gnt0", 32'({gnt_0, gnt_1}), 32'b10);
        tick(); idle_inputs();
        #2 check("t1_men",  32'({mem_enable, mem_write_en}), 32'b10);
        check("t1_addr", 32'(mem_address), 32'h010);
        tick();
        #2 check("t1_rv_t2", 32'({rvalid_0, rvalid_1}), 0);
        tick();
        #2 check("t1_rv_t3", 32'({rvalid_0, rvalid_1}), 32'b10);
        check("t1_rdata", rdata, 32'hA500_0010);
        tick();
        #2 check("t1_rv_t4", 32'({rvalid_0, rvalid_1}), 0);

        // Both requesting for 4 cycles: grants alternate, returns in order.
        do_reset();
        tick();
        for (int k = 0; k < 8; k++) begin
            req_0 = (k < 4); req_1 = (k < 4);
            addr_0 = 10'h020; addr_1 = 10'h030;
            #2;
            if (k < 4) check($sformatf("rr_gnt%0d", k), 32'({gnt_0, gnt_1}), (k % 2 == 0) ? 32'b10 : 32'b01);
            if (k >= 3 && k < 7) begin
                check($sformatf("rr_rv%0d", k), 32'({rvalid_0, rvalid_1}), ((k - 3) % 2 == 0) ? 32'b10 : 32'b01);
                check($sformatf("rr_rd%0d", k), rdata, ((k - 3) % 2 == 0) ? 32'hA500_0020 : 32'hA500_0030);
            end
            if (k == 7) check("rr_rv_end", 32'({rvalid_0, rvalid_1}), 0);
            tick();
        end
        idle_inputs();

        // Write from 1 then read from 0 at the same address.
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 10'h3FF; wdata_1 = 32'hDEAD_BEEF;
        #2 check("wr_gnt1", 32'({gnt_0, gnt_1}), 32'b01);
        tick(); idle_inputs();
        req_0 = 1'b1; addr_0 = 10'h3FF;
        #2 check("rd_gnt0", 32'({gnt_0, gnt_1}), 32'b10);
        check("wr_men",   32'({mem_enable, mem_write_en}), 32'b11);
        check("wr_addr",  32'(mem_address), 32'h3FF);
        check("wr_data",  mem_input_data, 32'hDEAD_BEEF);
        tick(); idle_inputs();
        #2 check("rd_men", 32'({mem_enable, mem_write_en}), 32'b10);
        tick();
        #2 check("wr_no_rv", 32'({rvalid_0, rvalid_1}), 0);
        tick();
        #2 check("rd_rv0", 32'({rvalid_0, rvalid_1}), 32'b10);
        check("rd_data", rdata, 32'hDEAD_BEEF);
        tick();

        // Init right after a read grant drops the read and resets the pointer.
        req_0 = 1'b1; addr_0 = 10'h040;
        #2 check("in_gnt0", 32'({gnt_0, gnt_1}), 32'b10);
        tick();
        req_0 = 1'b0; req_1 = 1'b1; addr_1 = 10'h050; init = 1'b1;
        #2 check("in_nognt", 32'({gnt_0, gnt_1}), 0);
        tick();
        init = 1'b0; req_0 = 1'b1;
        #2 check("in_ptr0", 32'({gnt_0, gnt_1}), 32'b10);
        check("in_men", 32'(mem_enable), 0);
        tick(); idle_inputs();
        #2 check("in_rv_drop", 32'({rvalid_0, rvalid_1}), 0);
        tick();
        #2 check("in_rv_g4", 32'({rvalid_0, rvalid_1}), 0);
        tick();
        #2 check("in_rv_new", 32'({rvalid_0, rvalid_1}), 32'b10);
        check("in_rdata", rdata, 32'hA500_0040);
        tick();

        // Async reset between gnt and rvalid.
        req_0 = 1'b1; addr_0 = 10'h060;
        #2 check("ar_gnt0", 32'({gnt_0, gnt_1}), 32'b10);
        tick();
        #2 check("ar_men_pre", 32'(mem_enable), 1);
        rst = 1'b1;
        #1 check("ar_men", 32'({mem_enable, mem_write_en}), 0);
        check("ar_addr", 32'(mem_address), 0);
        check("ar_gnt",  32'({gnt_0, gnt_1}), 0);
        check("ar_rv",   32'({rvalid_0, rvalid_1}), 0);
        tick(); idle_inputs();
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            #2 check($sformatf("ar_post%0d", k), 32'({rvalid_0, rvalid_1}), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
